// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic package: FSM state type and slice/counter sizing.
// Imported by the serial subtractor datapath.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } sub_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_STEP  = 1;

  function automatic int slices(
    input int width,
    input int step
  );
    return width / step;
  endfunction

  // One spare bit so that N=1 still yields a non-zero-width counter.
  function automatic int cnt_width(
    input int n
  );
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle.
// The controlling FSM is the master and the subtractor is the slave.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;
  logic             overflow;

  modport master (
    output start,
    output a,
    output b,
    output borrow_in,
    input  busy,
    input  done,
    input  difference,
    input  borrow,
    input  overflow
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  borrow_in,
    output busy,
    output done,
    output difference,
    output borrow,
    output overflow
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Chained STEP times per slice inside the serial subtractor.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: STEP bits per cycle through a
// chain of full subtractors, borrow registered between slices.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input logic            clk,
  input logic            rst_n,
  serial_subtractor_if.slave bus
);

  localparam int N  = slices(WIDTH, STEP);
  localparam int CW = cnt_width(N);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part;
  logic             bor;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;
  logic             overflow;

  logic [STEP:0]    chain;
  logic [STEP-1:0]  slice_d;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] part_nxt;
  logic             last;

  assign chain[0] = bor;

  for (genvar i = 0; i < STEP; i++) begin : g_fs
    full_subtractor u_fs (
      .a    (a_sh[i]),
      .b    (b_sh[i]),
      .bin  (chain[i]),
      .d    (slice_d[i]),
      .bout (chain[i+1])
    );
  end

  // New slice enters at the MSB end; after N slices it sits in place.
  assign slice_ext = WIDTH'(slice_d);
  assign part_nxt  = (part >> STEP)
                   | (slice_ext << (WIDTH - STEP));
  assign last      = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      part       <= '0;
      bor        <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            part  <= '0;
            bor   <= bus.borrow_in;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          a_sh <= a_sh >> STEP;
          b_sh <= b_sh >> STEP;
          part <= part_nxt;
          bor  <= chain[STEP];
          cnt  <= cnt + 1'b1;
          if (last) begin
            difference <= part_nxt;
            borrow     <= chain[STEP];
            overflow   <= (a_msb ^ b_msb)
                        & (part_nxt[WIDTH-1] ^ a_msb);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.difference = difference;
  assign bus.borrow     = borrow;
  assign bus.overflow   = overflow;

endmodule
